// File: rtl/aes_word_bridge.sv
// AES word bridge: gathers four 32-bit words from the input FIFO into one
// 128-bit block, runs a single encrypt or decrypt on the AES core, then
// drains the 128-bit result to the output FIFO most-significant word first.
module aes_word_bridge #(
  parameter int AES_TIMEOUT = 1023
) (
  input  logic         s00_axi_aclk,
  input  logic         s00_axi_areset,
  input  logic         ctrl_enc_start,
  input  logic         ctrl_dec_start,
  input  logic         key_ready,
  input  logic         fin_empty,
  input  logic [31:0]  fin_data,
  output logic         fin_rd_en,
  input  logic         fout_full,
  output logic         fout_wr_en,
  output logic [31:0]  fout_data,
  output logic         aes_start,
  output logic         aes_mode,
  output logic [127:0] aes_din,
  input  logic         aes_done,
  input  logic [127:0] aes_dout,
  output logic         busy_enc,
  output logic         busy_dec,
  output logic         err_nokey,
  output logic         err_timeout
);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, STORE} state_t;

  // Last WAIT-cycle count value before the core is declared dead.
  localparam logic [31:0] TIMEOUT_LAST = 32'(AES_TIMEOUT - 1);

  state_t       state;
  logic         mode;
  logic [1:0]   word_cnt;
  logic [31:0]  timer;
  logic [127:0] din_reg;
  logic [127:0] result;
  logic         nokey_flag;
  logic         timeout_flag;
  logic         start_req;

  assign start_req = ctrl_enc_start | ctrl_dec_start;

  // Control FSM: word gathering, core handshake with timeout, result drain.
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      state        <= IDLE;
      mode         <= 1'b0;
      word_cnt     <= 2'd0;
      timer        <= 32'd0;
      din_reg      <= 128'd0;
      result       <= 128'd0;
      nokey_flag   <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          word_cnt <= 2'd0;
          timer    <= 32'd0;
          if (start_req) begin
            if (key_ready) begin
              state        <= LOAD;
              mode         <= ~ctrl_enc_start;
              nokey_flag   <= 1'b0;
              timeout_flag <= 1'b0;
            end else begin
              nokey_flag <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (!fin_empty) begin
            case (word_cnt)
              2'd0:    din_reg[127:96] <= fin_data;
              2'd1:    din_reg[95:64]  <= fin_data;
              2'd2:    din_reg[63:32]  <= fin_data;
              default: din_reg[31:0]   <= fin_data;
            endcase
            word_cnt <= word_cnt + 2'd1;
            if (word_cnt == 2'd3) state <= START;
          end
        end
        START: begin
          timer <= 32'd0;
          state <= WAIT;
        end
        WAIT: begin
          if (aes_done) begin
            result   <= aes_dout;
            word_cnt <= 2'd0;
            state    <= STORE;
          end else if (timer == TIMEOUT_LAST) begin
            timeout_flag <= 1'b1;
            state        <= IDLE;
          end else begin
            timer <= timer + 32'd1;
          end
        end
        STORE: begin
          if (!fout_full) begin
            word_cnt <= word_cnt + 2'd1;
            if (word_cnt == 2'd3) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output word selection while draining the result register.
  always_comb begin
    fout_data = 32'd0;
    if (!s00_axi_areset && state == STORE) begin
      case (word_cnt)
        2'd0:    fout_data = result[127:96];
        2'd1:    fout_data = result[95:64];
        2'd2:    fout_data = result[63:32];
        default: fout_data = result[31:0];
      endcase
    end
  end

  // Strobes and status are forced low while reset is held, even before the
  // first reset edge has moved the FSM back to IDLE.
  assign fin_rd_en   = !s00_axi_areset && state == LOAD  && !fin_empty;
  assign fout_wr_en  = !s00_axi_areset && state == STORE && !fout_full;
  assign aes_start   = !s00_axi_areset && state == START;
  assign aes_mode    = !s00_axi_areset && mode;
  assign aes_din     = din_reg;
  assign busy_enc    = !s00_axi_areset && state != IDLE && !mode;
  assign busy_dec    = !s00_axi_areset && state != IDLE && mode;
  assign err_nokey   = !s00_axi_areset && nokey_flag;
  assign err_timeout = !s00_axi_areset && timeout_flag;

endmodule

// File: tb/tb_aes_word_bridge.sv
// Scoreboard bench for aes_word_bridge: FIFO and AES core are modelled here,
// expected core starts and output words are queued when stimulus is issued
// and checked by independent monitors.
module tb_aes_word_bridge;

  logic         clk = 1'b0;
  logic         reset;
  logic         ctrl_enc_start, ctrl_dec_start, key_ready;
  logic         fin_empty;
  logic [31:0]  fin_data;
  logic         fin_rd_en;
  logic         fout_full;
  logic         fout_wr_en;
  logic [31:0]  fout_data;
  logic         aes_start, aes_mode;
  logic [127:0] aes_din;
  logic         aes_done;
  logic [127:0] aes_dout;
  logic         busy_enc, busy_dec, err_nokey, err_timeout;

  int total = 0;
  int bad   = 0;
  int pops  = 0;
  int pops0;
  int core_lat = 14;
  logic core_never = 1'b0;
  logic [127:0] core_result = 128'd0;

  logic [31:0]  fifo_q[$];
  logic [31:0]  exp_out_q[$];
  logic [128:0] exp_start_q[$];

  localparam logic [127:0] PT = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT = 128'hdeae1a89b07f6e26246b3283cef7b78c;

  aes_word_bridge #(.AES_TIMEOUT(15)) dut (
    .s00_axi_aclk(clk), .s00_axi_areset(reset),
    .ctrl_enc_start(ctrl_enc_start), .ctrl_dec_start(ctrl_dec_start),
    .key_ready(key_ready), .fin_empty(fin_empty), .fin_data(fin_data),
    .fin_rd_en(fin_rd_en), .fout_full(fout_full), .fout_wr_en(fout_wr_en),
    .fout_data(fout_data), .aes_start(aes_start), .aes_mode(aes_mode),
    .aes_din(aes_din), .aes_done(aes_done), .aes_dout(aes_dout),
    .busy_enc(busy_enc), .busy_dec(busy_dec),
    .err_nokey(err_nokey), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One-cycle control pulse; returns at the following negedge.
  task automatic applyStimulus(input logic enc, input logic dec);
    @(negedge clk);
    ctrl_enc_start = enc;
    ctrl_dec_start = dec;
    @(negedge clk);
    ctrl_enc_start = 1'b0;
    ctrl_dec_start = 1'b0;
  endtask

  task automatic push_words(input logic [127:0] blk, input int first, input int count);
    for (int i = first; i < first + count; i++) fifo_q.push_back(blk[127 - 32*i -: 32]);
  endtask

  task automatic expect_block(input logic [127:0] din, input logic mode, input logic [127:0] res);
    exp_start_q.push_back({mode, din});
    for (int i = 0; i < 4; i++) exp_out_q.push_back(res[127 - 32*i -: 32]);
    core_result = res;
  endtask

  task automatic wait_idle(input string name, input int max_cycles);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy_enc || busy_dec) && n < max_cycles);
    checkOutput(name, {127'd0, busy_enc | busy_dec}, 128'd0);
  endtask

  // Input FIFO model: first-word-fall-through, pops after the edge it was read on.
  always begin
    logic pend;
    @(negedge clk);
    pend = fin_rd_en;
    @(posedge clk);
    #1;
    if (pend && fifo_q.size() > 0) begin
      void'(fifo_q.pop_front());
      pops++;
    end
    fin_empty = (fifo_q.size() == 0);
    fin_data  = fin_empty ? 32'd0 : fifo_q[0];
  end

  // AES core model: checks the start against the scoreboard, then answers.
  always begin
    logic [128:0] e;
    @(negedge clk);
    if (aes_start) begin
      total++;
      if (exp_start_q.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected_start: got mode=%0b din=%h expected none", aes_mode, aes_din);
      end else begin
        e = exp_start_q.pop_front();
        if ({aes_mode, aes_din} !== e) begin
          bad++;
          $display("[TB] FAIL core_start: got mode=%0b din=%h expected mode=%0b din=%h",
                   aes_mode, aes_din, e[128], e[127:0]);
        end
      end
      if (!core_never) begin
        repeat (core_lat) @(posedge clk);
        #1;
        aes_done = 1'b1;
        aes_dout = core_result;
        @(posedge clk);
        #1;
        aes_done = 1'b0;
      end
    end
  end

  // Output FIFO monitor: every push must match the next expected word and
  // must never happen while the FIFO reports full.
  always @(negedge clk) begin
    if (fout_wr_en) begin
      total++;
      if (fout_full) begin
        bad++;
        $display("[TB] FAIL push_while_full: got data %h with fout_full=1 expected no push", fout_data);
      end else if (exp_out_q.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected_push: got %h expected none", fout_data);
      end else begin
        logic [31:0] e;
        e = exp_out_q.pop_front();
        if (fout_data !== e) begin
          bad++;
          $display("[TB] FAIL out_word: got %h expected %h", fout_data, e);
        end
      end
    end
  end

  initial begin
    #200000;
    bad++;
    $display("[TB] FAIL global_timeout: got no finish expected finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int n;
    reset = 1'b1;
    ctrl_enc_start = 1'b0;
    ctrl_dec_start = 1'b0;
    key_ready = 1'b1;
    fin_empty = 1'b1;
    fin_data = 32'd0;
    fout_full = 1'b0;
    aes_done = 1'b0;
    aes_dout = 128'd0;
    repeat (3) @(negedge clk);
    checkOutput("rst_strobes", {120'd0, fin_rd_en, fout_wr_en, aes_start, aes_mode,
                busy_enc, busy_dec, err_nokey, err_timeout}, 128'd0);
    checkOutput("rst_fout_data", {96'd0, fout_data}, 128'd0);
    checkOutput("rst_aes_din", aes_din, 128'd0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("idle_busy", {126'd0, busy_enc, busy_dec}, 128'd0);

    // Encrypt of the reference block
    $display("[TB] encrypt reference block");
    push_words(PT, 0, 4);
    expect_block(PT, 1'b0, CT);
    pops0 = pops;
    applyStimulus(1'b1, 1'b0);
    checkOutput("enc_busy", {126'd0, busy_enc, busy_dec}, 128'd2);
    wait_idle("enc_idle", 200);
    checkOutput("enc_pops", 128'(pops - pops0), 128'd4);

    // Decrypt of the ciphertext
    $display("[TB] decrypt reference block");
    push_words(CT, 0, 4);
    expect_block(CT, 1'b1, PT);
    applyStimulus(1'b0, 1'b1);
    checkOutput("dec_busy", {126'd0, busy_enc, busy_dec}, 128'd1);
    wait_idle("dec_idle", 200);

    // Start without key is rejected, later accepted start clears the error
    $display("[TB] key not ready");
    key_ready = 1'b0;
    push_words(128'h11111111222222223333333344444444, 0, 4);
    pops0 = pops;
    applyStimulus(1'b1, 1'b0);
    checkOutput("nokey_err", {127'd0, err_nokey}, 128'd1);
    checkOutput("nokey_busy", {126'd0, busy_enc, busy_dec}, 128'd0);
    repeat (4) @(negedge clk);
    checkOutput("nokey_pops", 128'(pops - pops0), 128'd0);
    key_ready = 1'b1;
    expect_block(128'h11111111222222223333333344444444, 1'b0,
                 128'hcafef00d123456789abcdef00badbeef);
    applyStimulus(1'b1, 1'b0);
    checkOutput("nokey_clear", {127'd0, err_nokey}, 128'd0);
    wait_idle("nokey_idle", 200);

    // Stalled load, ignored start while busy, back-pressured store
    $display("[TB] stalls");
    push_words(128'h55555555666666667777777788888888, 0, 2);
    expect_block(128'h55555555666666667777777788888888, 1'b0,
                 128'h0123456789abcdeffedcba9876543210);
    pops0 = pops;
    applyStimulus(1'b1, 1'b0);
    repeat (20) @(negedge clk);
    checkOutput("stall_pops", 128'(pops - pops0), 128'd2);
    applyStimulus(1'b0, 1'b1);
    checkOutput("busy_ignore", {125'd0, busy_enc, busy_dec, err_nokey}, 128'd4);
    push_words(128'h55555555666666667777777788888888, 2, 2);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!aes_done && n < 100);
    checkOutput("stall_done_seen", {127'd0, aes_done}, 128'd1);
    fout_full = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("full_busy", {127'd0, busy_enc}, 128'd1);
    fout_full = 1'b0;
    wait_idle("stall_idle", 50);
    checkOutput("stall_pops_total", 128'(pops - pops0), 128'd4);

    // Core never answers; simultaneous pulses pick encrypt
    $display("[TB] timeout");
    core_never = 1'b1;
    push_words(128'h99999999aaaaaaaabbbbbbbbcccccccc, 0, 4);
    exp_start_q.push_back({1'b0, 128'h99999999aaaaaaaabbbbbbbbcccccccc});
    applyStimulus(1'b1, 1'b1);
    n = 0;
    while (!aes_start && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("to_start_seen", {127'd0, aes_start}, 128'd1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy_enc && n < 100);
    checkOutput("to_cycles", 128'(n), 128'd16);
    checkOutput("to_flags", {126'd0, err_timeout, err_nokey}, 128'd2);
    core_never = 1'b0;

    // Stray done while idle must not push
    @(negedge clk);
    aes_dout = 128'hffffffffeeeeeeeeddddddddcccccccc;
    aes_done = 1'b1;
    @(negedge clk);
    aes_done = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("stray_done_busy", {126'd0, busy_enc, busy_dec}, 128'd0);

    // Next accepted start clears the timeout flag
    push_words(128'h0f0e0d0c0b0a09080706050403020100, 0, 4);
    expect_block(128'h0f0e0d0c0b0a09080706050403020100, 1'b1,
                 128'h13579bdf2468ace0fdb97531eca86420);
    applyStimulus(1'b0, 1'b1);
    checkOutput("to_clear", {126'd0, err_timeout, busy_dec}, 128'd1);
    wait_idle("to_clear_idle", 200);

    // Reset in the middle of a block abandons it
    $display("[TB] mid-operation reset");
    push_words(128'hdeadbeef00000000feedface11111111, 0, 4);
    exp_start_q.push_back({1'b0, 128'hdeadbeef00000000feedface11111111});
    core_result = 128'h0;
    applyStimulus(1'b1, 1'b0);
    n = 0;
    while (!aes_start && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_strobes", {120'd0, fin_rd_en, fout_wr_en, aes_start, aes_mode,
                busy_enc, busy_dec, err_nokey, err_timeout}, 128'd0);
    checkOutput("mid_rst_din", aes_din, 128'd0);
    reset = 1'b0;
    repeat (25) @(negedge clk);
    checkOutput("mid_rst_idle", {126'd0, busy_enc, busy_dec}, 128'd0);

    checkOutput("sb_empty", 128'(exp_out_q.size() + exp_start_q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
